fpu_phase_seq: RTL and testbench

//  Parametrised phase sequencer for the FPU datapath; generalises the fixed 2-bit add/mul/sub

---
 rtl/fpu_seq_pkg.sv | 25 ++
 rtl/fpu_seq_cnt.sv | 42 ++++
 rtl/fpu_phase_seq.sv | 161 ++++++++++++++++
 tb/tb_fpu_phase_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg
// Shared definitions for the FPU phase sequencer.
//   - State encodings and the enum type used by the sequencer FSM
//   - Default values for the stage count and the per-stage length field width
//   - Stage indices of the original add/mul/sub sequencer (three-stage configuration)
package fpu_seq_pkg;

  localparam int NUM_STAGES_DEF = 3;
  localparam int CYC_W_DEF      = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } seq_state_e;

  localparam int STG_ADD = 0;
  localparam int STG_MUL = 1;
  localparam int STG_SUB = 2;

endpackage

// File: rtl/fpu_seq_cnt.sv
// fpu_seq_cnt
// Per-stage cycle down-counter. It is loaded with (length - 1) on stage entry
// and then counts down to zero. It stops at zero and waits for the next load.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (clears the count)
//   load      in   load load_val (has priority over counting)
//   load_val  in   CYC_W value to load
//   en        in   counting allowed this cycle
//   hold      in   freeze the count
//   cnt       out  current count
//   zero      out  count is zero
module fpu_seq_cnt #(
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CYC_W-1:0] load_val,
  input  logic             en,
  input  logic             hold,
  output logic [CYC_W-1:0] cnt,
  output logic             zero
);

  logic [CYC_W-1:0] cnt_q;

  // The count never goes below zero. The owner reloads it on the zero cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && !hold && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CYC_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fpu_phase_seq.sv
// fpu_phase_seq
// Phase sequencer for the FPU datapath. It steps through NUM_STAGES phases.
// Each phase is held for a programmable number of cycles, and a length of 0 counts as 1.
// The interface is a start/done handshake, plus a stall input (hold) and an abort input.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request a sequence (accepted when ready)
//   stage_len   in   per-stage lengths, field i = [i*CYC_W +: CYC_W], sampled on accept
//   hold        in   stall the running sequence
//   abort       in   cancel the running sequence
//   ready       out  idle or done, so a start will be taken
//   busy        out  sequence running
//   stage_vld   out  one-hot valid of the current phase
//   stage_idx   out  index of the current phase
//   stage_last  out  final cycle of the current phase
//   done        out  one-cycle completion pulse
module fpu_phase_seq
  import fpu_seq_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int CYC_W      = CYC_W_DEF,
  localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_STAGES*CYC_W-1:0] stage_len,
  input  logic                        hold,
  input  logic                        abort,
  output logic                        ready,
  output logic                        busy,
  output logic [NUM_STAGES-1:0]       stage_vld,
  output logic [IDX_W-1:0]            stage_idx,
  output logic                        stage_last,
  output logic                        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  seq_state_e                  state_q, state_d;
  logic [NUM_STAGES*CYC_W-1:0] len_q;
  logic [IDX_W-1:0]            idx_q;
  logic [IDX_W-1:0]            next_idx;
  logic [CYC_W-1:0]            len_m1 [NUM_STAGES];
  logic [CYC_W-1:0]            first_m1;
  logic [CYC_W-1:0]            cnt_val;
  logic [CYC_W-1:0]            cnt;
  logic                        cnt_zero;
  logic                        cnt_load;
  logic                        cnt_en;
  logic                        is_run;
  logic                        is_ready;
  logic                        accept;
  logic                        at_last;
  logic                        step;
  logic                        kill;

  // Reload values (effective length - 1). A zero length behaves as one cycle.
  // Stage 0 is loaded at the accept edge, so its value comes straight from the
  // input and not from the shadow registers, which are written on that same edge.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      len_m1[i] = (len_q[i*CYC_W +: CYC_W] == '0) ? '0
                                                  : len_q[i*CYC_W +: CYC_W] - CYC_W'(1);
    end
    first_m1 = (stage_len[0 +: CYC_W] == '0) ? '0 : stage_len[0 +: CYC_W] - CYC_W'(1);
  end

  // Control decodes. Abort outranks hold, and hold outranks advancing a phase.
  always_comb begin
    is_run   = (state_q == S_RUN);
    is_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    accept   = is_ready && start;
    at_last  = (idx_q == LAST_IDX);
    kill     = is_run && abort;
    step     = is_run && !abort && !hold && cnt_zero;
    next_idx = at_last ? idx_q : idx_q + IDX_W'(1);
    cnt_en   = is_run && !abort;
    cnt_load = accept || kill || (step && !at_last);
    if (accept) begin
      cnt_val = first_m1;
    end else if (kill) begin
      cnt_val = '0;
    end else begin
      cnt_val = len_m1[next_idx];
    end
  end

  fpu_seq_cnt #(
    .CYC_W (CYC_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .hold     (hold),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort only acts in RUN, so in DONE a start always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (step && at_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow lengths and stage index. The lengths are captured only on accept,
  // so later changes to stage_len do not affect a sequence that is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      idx_q <= '0;
    end else begin
      if (accept) begin
        len_q <= stage_len;
      end
      if (accept || kill) begin
        idx_q <= '0;
      end else if (step) begin
        idx_q <= at_last ? '0 : next_idx;
      end
    end
  end

  // Output decode. Every output depends only on registered state.
  always_comb begin
    ready      = is_ready;
    busy       = is_run;
    done       = (state_q == S_DONE);
    stage_vld  = '0;
    stage_idx  = '0;
    stage_last = is_run && cnt_zero;
    if (is_run) begin
      stage_vld[idx_q] = 1'b1;
      stage_idx        = idx_q;
    end
  end

endmodule

// File: tb/tb_fpu_phase_seq.sv
// tb_fpu_phase_seq
// Directed testbench for fpu_phase_seq with NUM_STAGES=3 and CYC_W=4.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled
// at that same point. The expected output vector is
// {ready, busy, stage_vld[2:0], stage_idx[1:0], stage_last, done}.
module tb_fpu_phase_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] stage_len;
  logic        hold;
  logic        abort;
  logic        ready;
  logic        busy;
  logic [2:0]  stage_vld;
  logic [1:0]  stage_idx;
  logic        stage_last;
  logic        done;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [8:0] EXP_IDLE = 9'b1_0_000_00_0_0;
  localparam logic [8:0] EXP_DONE = 9'b1_0_000_00_0_1;

  fpu_phase_seq #(
    .NUM_STAGES (3),
    .CYC_W      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stage_len  (stage_len),
    .hold       (hold),
    .abort      (abort),
    .ready      (ready),
    .busy       (busy),
    .stage_vld  (stage_vld),
    .stage_idx  (stage_idx),
    .stage_last (stage_last),
    .done       (done)
  );

  // Free-running clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] exp_run(input logic [2:0] vld, input logic [1:0] idx,
                                         input logic last);
    return {1'b0, 1'b1, vld, idx, last, 1'b0};
  endfunction

  task automatic applyStimulus(input logic s, input logic h, input logic a,
                               input logic [11:0] lens);
    start     = s;
    hold      = h;
    abort     = a;
    stage_len = lens;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] expected);
    logic [8:0] observed;
    observed = {ready, busy, stage_vld, stage_idx, stage_last, done};
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Directed sequence of test steps
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    #12;
    checkOutput("reset_state", EXP_IDLE);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_after_reset", EXP_IDLE);

    // Lengths {1,1,1}: one cycle per phase, done four cycles after the start edge
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h111);
    tick(); checkOutput("basic_t1", exp_run(3'b001, 2'd0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h111);
    tick(); checkOutput("basic_t2", exp_run(3'b010, 2'd1, 1'b1));
    tick(); checkOutput("basic_t3", exp_run(3'b100, 2'd2, 1'b1));
    tick(); checkOutput("basic_done", EXP_DONE);
    tick(); checkOutput("basic_idle", EXP_IDLE);

    // Lengths {3,0,2}: stage 1 length 0 counts as 1, so busy lasts 6 cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h203);
    tick(); checkOutput("len_t1", exp_run(3'b001, 2'd0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h203);
    tick(); checkOutput("len_t2", exp_run(3'b001, 2'd0, 1'b0));
    tick(); checkOutput("len_t3", exp_run(3'b001, 2'd0, 1'b1));
    tick(); checkOutput("len_t4", exp_run(3'b010, 2'd1, 1'b1));
    tick(); checkOutput("len_t5", exp_run(3'b100, 2'd2, 1'b0));
    tick(); checkOutput("len_t6", exp_run(3'b100, 2'd2, 1'b1));
    tick(); checkOutput("len_done", EXP_DONE);
    tick(); checkOutput("len_idle", EXP_IDLE);

    // Hold for two cycles during stage 1 of {1,1,1}, so done arrives at T+6
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h111);
    tick(); checkOutput("hold_t1", exp_run(3'b001, 2'd0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h111);
    tick(); checkOutput("hold_t2", exp_run(3'b010, 2'd1, 1'b1));
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h111);
    tick(); checkOutput("hold_t3", exp_run(3'b010, 2'd1, 1'b1));
    tick(); checkOutput("hold_t4", exp_run(3'b010, 2'd1, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h111);
    tick(); checkOutput("hold_t5", exp_run(3'b100, 2'd2, 1'b1));
    tick(); checkOutput("hold_done", EXP_DONE);
    tick(); checkOutput("hold_idle", EXP_IDLE);

    // Hold is ignored in IDLE, so start is still accepted; then hold freezes the run
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h111);
    tick(); checkOutput("hold_idle_start", exp_run(3'b001, 2'd0, 1'b1));
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h111);
    tick(); checkOutput("hold_freeze", exp_run(3'b001, 2'd0, 1'b1));
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h111);
    tick(); checkOutput("abort_over_hold", EXP_IDLE);

    // Abort on the second cycle of stage 0 with {4,4,4}, then restart
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h444);
    tick(); checkOutput("abort_t1", exp_run(3'b001, 2'd0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h444);
    tick(); checkOutput("abort_t2", exp_run(3'b001, 2'd0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h444);
    tick(); checkOutput("abort_idle", EXP_IDLE);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h444);
    tick(); checkOutput("abort_restart", exp_run(3'b001, 2'd0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h444);
    tick(); checkOutput("abort_again", EXP_IDLE);
    tick(); checkOutput("abort_in_idle", EXP_IDLE);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h444);
    tick(); checkOutput("abort_no_done", EXP_IDLE);

    // Reset asserted in the middle of a run takes effect at once, and no done follows
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h444);
    tick(); checkOutput("rst_run_t1", exp_run(3'b001, 2'd0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h444);
    tick(); checkOutput("rst_run_t2", exp_run(3'b001, 2'd0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", EXP_IDLE);
    tick();
    rst_n = 1'b1;
    tick(); checkOutput("rst_release", EXP_IDLE);
    tick(); checkOutput("rst_no_done", EXP_IDLE);

    // Back-to-back with start held high, lengths {1,2,1}: done every 5 cycles.
    // stage_len changes during the run must not affect the running sequence.
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h121);
    tick(); checkOutput("b2b_t1", exp_run(3'b001, 2'd0, 1'b1));
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h333);
    tick(); checkOutput("b2b_t2", exp_run(3'b010, 2'd1, 1'b0));
    tick(); checkOutput("b2b_t3", exp_run(3'b010, 2'd1, 1'b1));
    tick(); checkOutput("b2b_t4", exp_run(3'b100, 2'd2, 1'b1));
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h121);
    tick(); checkOutput("b2b_done1", EXP_DONE);
    tick(); checkOutput("b2b_t6", exp_run(3'b001, 2'd0, 1'b1));
    tick(); checkOutput("b2b_t7", exp_run(3'b010, 2'd1, 1'b0));
    tick(); checkOutput("b2b_t8", exp_run(3'b010, 2'd1, 1'b1));
    tick(); checkOutput("b2b_t9", exp_run(3'b100, 2'd2, 1'b1));
    tick(); checkOutput("b2b_done2", EXP_DONE);
    // Start and abort together in DONE: start wins
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h121);
    tick(); checkOutput("done_start_wins", exp_run(3'b001, 2'd0, 1'b1));
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h121);
    tick(); checkOutput("b2b_abort", EXP_IDLE);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h121);
    tick(); checkOutput("final_idle", EXP_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
